wb_port_scheduler: RTL and testbench
====================================

# wb_port_scheduler

Writeback-port scheduler shared by all issue queues in the backend. Each cycle it grants issue to requesters whose functional-unit latency lands on a free slot of the single shared result bus. It keeps a cycle-accurate reservation map of that bus and uses round-robin priority with a starvation override. Grants go back to the issue queues in the same cycle; the reservation map drives result-bus valid timing for the register file and wakeup logic.

## Interface
- NUM_REQ, 4: number of requesting issue queues.
- MAX_LAT, 8: largest legal FU latency in cycles, 1..31.
- LAT_W, 5: width of a latency field.
- STARVE_MAX, 7: consecutive denied cycles after which a requester becomes starved; counter width is $clog2(STARVE_MAX+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IN_stall  in  1  backend stall; no grants this cycle.
- IN_flush  in  1  branch mispredict flush; no grants this cycle, starvation state cleared.
- IN_req  in  NUM_REQ  request valid per queue.
- IN_reqLat  in  NUM_REQ*LAT_W  latency of the candidate uop per queue; field i is at bits [i*LAT_W +: LAT_W].
- OUT_grant  out  NUM_REQ  combinational grant, one-hot or multi-hot.
- OUT_wbBusy  out  MAX_LAT+1  registered reservation map R; bit k set means the bus is taken k cycles from now.
- OUT_wbValid  out  1  equals R[0]; result bus is in use this cycle.
- OUT_starved  out  NUM_REQ  registered; counter i is at STARVE_MAX.

## Operation
- State: reservation vector R[MAX_LAT:0], round-robin pointer ptr (0..NUM_REQ-1), and one saturating counter cnt[i] per requester.
- Legality: request i is eligible only when all of the following hold:
  - IN_req[i] is set;
  - 1 ≤ lat_i ≤ MAX_LAT;
  - IN_stall and IN_flush are both low;
  - rst is high.
- An illegal latency is never granted and never counts toward starvation.
- Scan order:
  - First, starved requesters (cnt==STARVE_MAX) in ascending index.
  - Then all others in round-robin order starting at ptr, wrapping modulo NUM_REQ.
- Grant rule: walk the scan order and grant eligible i if R[lat_i]==0 and no earlier grant in this cycle claimed the same lat. Several grants per cycle are allowed when their latencies are distinct.
- Next R: R' = (R >> 1) | OR over granted i of (1 << (lat_i − 1)). The top bit shifts in 0. Stall and flush still shift R; in-flight and squashed ops keep their slots.
- ptr: if any non-starved requester was granted, ptr' = (index of the last non-starved grant in scan order + 1) mod NUM_REQ. Otherwise ptr holds.
- cnt[i]:
  - flush: 0.
  - granted: 0.
  - eligible by legality but not granted, and not stalled: min(cnt+1, STARVE_MAX).
  - otherwise: holds.
- Arithmetic: latency compares are unsigned in LAT_W bits. R is indexed only after the range check.

## Timing
- OUT_grant is combinational from IN_req, IN_reqLat, IN_stall, IN_flush and registered state, with zero cycles of latency. The issue queue dequeues in the same cycle.
- A grant with latency L at edge t makes OUT_wbValid high in exactly cycle t+L. After the edge, R[L−1]=1.
- Reset (rst low, asynchronous):
  - R=0, ptr=0, cnt=0.
  - OUT_grant=0, OUT_wbBusy=0, OUT_wbValid=0, OUT_starved=0 immediately, even mid-operation.
  - Reservations are discarded.
- First possible grant is in the cycle after rst deasserts.
- Flush and stall in the same cycle: flush semantics apply.
- A request with latency MAX_LAT is checked against R[MAX_LAT], which is always 0 after a shift. It is granted unless a same-cycle grant has the same latency.
- Full bus (R[1..MAX_LAT] all set): no grants. All eligible requesters increment cnt.

## Test plan
- Single request, lat=3, idle bus -> OUT_grant=0001. OUT_wbBusy=0b000000100 after the edge. OUT_wbValid high exactly 3 cycles after grant.
- Requesters 0 and 1 both at lat=2, ptr=0 -> grant 0001 only. Next cycle with the same requests, ptr=1 and slot 2 is free again -> grant 0010.
- Requesters 0, 1, 2 with lat=1, 2, 2, ptr=0 -> grant 0011. R after the edge has bits 0 and 1 set.
- Requester 3 (lat=4) is repeatedly blocked by requester 2 pre-occupying slot 4 for 7 cycles -> OUT_starved[3]=1. On the next cycle 3 and 2 both request lat=4 -> 3 is granted, its cnt resets, and OUT_starved[3] clears.
- Latency 0 or 9 with MAX_LAT=8 -> never granted, cnt stays 0. Flush with 3 requests -> no grant, all cnt=0, R still shifts.
- Assert rst low mid-stream with R=0b101010101 -> all outputs 0 asynchronously. After release, a lat=1 request is granted on the first cycle.

Source files
------------

// File: rtl/wb_port_scheduler.sv
// rtl/wb_port_scheduler.sv - shared result-bus writeback scheduler with reservation map and starvation override
module wb_port_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_LAT    = 8,
    parameter int LAT_W      = 5,
    parameter int STARVE_MAX = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_stall,
    input  logic                       IN_flush,
    input  logic [NUM_REQ-1:0]         IN_req,
    input  logic [NUM_REQ*LAT_W-1:0]   IN_reqLat,
    output logic [NUM_REQ-1:0]         OUT_grant,
    output logic [MAX_LAT:0]           OUT_wbBusy,
    output logic                       OUT_wbValid,
    output logic [NUM_REQ-1:0]         OUT_starved
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EW = 1 << LAT_W;

    logic [MAX_LAT:0]    wb_map;
    logic [MAX_LAT:0]    wb_map_nxt;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_nxt;
    logic [CW-1:0]       cnt [NUM_REQ];

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  starved;
    logic [NUM_REQ-1:0]  grant;
    logic [EW-1:0]       map_ext;
    logic [EW-1:0]       claim;
    logic [LAT_W-1:0]    lat_i;
    logic [LAT_W-1:0]    lat_k;
    logic [PW-1:0]       idx;
    logic                pick;

    always_comb begin
        // Zero-extended map lets any latency value index safely; range is checked via eligible.
        map_ext  = EW'(wb_map);
        claim    = '0;
        grant    = '0;
        ptr_nxt  = ptr;
        lat_i    = '0;
        lat_k    = '0;
        idx      = '0;
        pick     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lat_i       = IN_reqLat[i*LAT_W +: LAT_W];
            starved[i]  = (cnt[i] == CW'(STARVE_MAX));
            eligible[i] = IN_req[i] && (lat_i >= LAT_W'(1)) && (lat_i <= LAT_W'(MAX_LAT))
                          && !IN_stall && !IN_flush && rst;
        end
        // Pass one: starved requesters by index; pass two: the rest round-robin from ptr.
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (k < NUM_REQ) begin
                idx  = PW'(k);
                pick = starved[idx];
            end else begin
                idx  = PW'((int'(ptr) + k - NUM_REQ) % NUM_REQ);
                pick = !starved[idx];
            end
            lat_k = IN_reqLat[idx*LAT_W +: LAT_W];
            if (pick && eligible[idx] && !map_ext[lat_k] && !claim[lat_k]) begin
                grant[idx]   = 1'b1;
                claim[lat_k] = 1'b1;
                if (k >= NUM_REQ)
                    ptr_nxt = PW'((int'(idx) + 1) % NUM_REQ);
            end
        end
        wb_map_nxt = {1'b0, wb_map[MAX_LAT:1]} | claim[MAX_LAT+1:1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_map <= '0;
            ptr    <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= '0;
        end else begin
            wb_map <= wb_map_nxt;
            ptr    <= ptr_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IN_flush || grant[i])
                    cnt[i] <= '0;
                else if (eligible[i] && !starved[i])
                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    assign OUT_grant   = grant;
    assign OUT_wbBusy  = wb_map;
    assign OUT_wbValid = wb_map[0];
    assign OUT_starved = starved;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb/tb_wb_port_scheduler.sv - directed vector bench for wb_port_scheduler
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [3:0]  req;
    logic [19:0] lat;
    logic [3:0]  grant;
    logic [8:0]  busy;
    logic        valid;
    logic [3:0]  starved;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [3:0]  req;
        logic [19:0] lat;
        logic [3:0]  exp_grant;
        logic [8:0]  exp_busy;
    } vec_t;

    vec_t vecs [16];

    wb_port_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .IN_stall   (stall),
        .IN_flush   (flush),
        .IN_req     (req),
        .IN_reqLat  (lat),
        .OUT_grant  (grant),
        .OUT_wbBusy (busy),
        .OUT_wbValid(valid),
        .OUT_starved(starved)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] lp(int a, int b, int c, int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, id, act, exp);
        end
    endtask

    task automatic drive(logic s, logic f, logic [3:0] r, logic [19:0] l);
        stall = s;
        flush = f;
        req   = r;
        lat   = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 4'b0011, lp(2, 2, 0, 0), 4'b0001, 9'b000000010};
        vecs[1]  = '{1'b0, 1'b0, 4'b0011, lp(2, 2, 0, 0), 4'b0010, 9'b000000011};
        vecs[2]  = '{1'b0, 1'b0, 4'b0001, lp(3, 0, 0, 0), 4'b0001, 9'b000000101};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b000000010};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b000000001};
        vecs[5]  = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b000000000};
        vecs[6]  = '{1'b0, 1'b0, 4'b1000, lp(0, 0, 0, 1), 4'b1000, 9'b000000001};
        vecs[7]  = '{1'b0, 1'b0, 4'b0111, lp(1, 2, 2, 0), 4'b0011, 9'b000000011};
        vecs[8]  = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b000000001};
        vecs[9]  = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b000000000};
        vecs[10] = '{1'b0, 1'b0, 4'b0011, lp(0, 9, 0, 0), 4'b0000, 9'b000000000};
        vecs[11] = '{1'b0, 1'b0, 4'b0001, lp(5, 0, 0, 0), 4'b0001, 9'b000010000};
        vecs[12] = '{1'b0, 1'b1, 4'b0111, lp(1, 2, 3, 0), 4'b0000, 9'b000001000};
        vecs[13] = '{1'b1, 1'b0, 4'b0111, lp(1, 2, 3, 0), 4'b0000, 9'b000000100};
        vecs[14] = '{1'b0, 1'b0, 4'b0011, lp(8, 8, 0, 0), 4'b0010, 9'b010000010};
        vecs[15] = '{1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0), 4'b0000, 9'b001000001};

        // reset holds every output low even with a request pending
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'b0001, lp(3, 0, 0, 0));
        #12;
        chk("rst_grant", 0, 32'(grant), 32'h0);
        chk("rst_busy", 0, 32'(busy), 32'h0);
        chk("rst_valid", 0, 32'(valid), 32'h0);
        chk("rst_starved", 0, 32'(starved), 32'h0);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0));
        cyc();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].req, vecs[i].lat);
            #1;
            chk("grant", i, 32'(grant), 32'(vecs[i].exp_grant));
            cyc();
            chk("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
            chk("valid", i, 32'(valid), 32'(vecs[i].exp_busy[0]));
            chk("starved", i, 32'(starved), 32'h0);
        end

        // drain, then fill alternating slots and reset asynchronously mid-cycle
        drive(1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0));
        for (int i = 0; i < 9; i++) cyc();
        chk("drain_busy", 0, 32'(busy), 32'h0);
        drive(1'b0, 1'b0, 4'b1111, lp(2, 4, 6, 8));
        #1;
        chk("multi_grant", 0, 32'(grant), 32'hf);
        cyc();
        chk("multi_busy", 0, 32'(busy), 32'h0aa);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 0, 32'(grant), 32'h0);
        chk("arst_busy", 0, 32'(busy), 32'h0);
        chk("arst_valid", 0, 32'(valid), 32'h0);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0001, lp(1, 0, 0, 0));
        #1;
        chk("post_rst_grant", 0, 32'(grant), 32'h1);
        cyc();
        chk("post_rst_busy", 0, 32'(busy), 32'h1);
        chk("post_rst_valid", 0, 32'(valid), 32'h1);
        drive(1'b0, 1'b0, 4'b0000, lp(0, 0, 0, 0));
        cyc();

        // requester 3 starved by requester 2 holding slot 4 every cycle
        drive(1'b0, 1'b0, 4'b0100, lp(0, 0, 5, 0));
        #1;
        chk("prime_grant", 0, 32'(grant), 32'h4);
        cyc();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b0, 4'b1100, lp(0, 0, 5, 4));
            #1;
            chk("block_grant", i, 32'(grant), 32'h4);
            cyc();
            chk("block_starved", i, 32'(starved), 32'h0);
        end
        drive(1'b0, 1'b0, 4'b1000, lp(0, 0, 0, 4));
        #1;
        chk("block_grant", 7, 32'(grant), 32'h0);
        cyc();
        chk("starved_set", 0, 32'(starved), 32'h8);
        drive(1'b0, 1'b0, 4'b1100, lp(0, 0, 4, 4));
        #1;
        chk("starve_override", 0, 32'(grant), 32'h8);
        cyc();
        chk("starved_clear", 0, 32'(starved), 32'h0);
        chk("starve_busy_bit3", 0, 32'(busy[3]), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
